// File: rtl/pc_fetch_unit.sv
// Program-counter register and instruction-fetch sequencer.
// Holds the PC and fetches one instruction per S_REQ/S_HOLD pair over a
// req/ack memory handshake. It presents the fetched instruction and its
// address to IF/ID.
// Optional feature: define PC_FETCH_TIMEOUT_EN to bound the S_REQ wait.
// When it is undefined the unit waits for ack forever and fetch_timeout reads 0.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] next_pc,
    input  logic        stall,
    input  logic        flush,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic        instr_valid,
    output logic [31:0] pc_plus4,
    output logic        misaligned,
    output logic        fetch_timeout
);

    typedef enum logic [1:0] {StIdle, StReq, StHold, StErr} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic        valid_q, valid_d;
    logic        misaligned_q, misaligned_d;
    logic        flush_pend_q, flush_pend_d;
    logic [31:0] flush_tgt_q, flush_tgt_d;
    logic        load_en;
    logic [31:0] load_addr;

`ifdef PC_FETCH_TIMEOUT_EN
    localparam logic [4:0] TimeoutLim = 5'(TIMEOUT_CYCLES);
    logic [4:0] wait_q, wait_d;
    logic       timeout_q, timeout_d;
`endif

    assign imem_req    = (state_q == StReq);
    assign imem_addr   = pc_q;
    assign pc_plus4    = pc_q + 32'd4;
    assign instr_out   = instr_q;
    assign pc_out      = pc_out_q;
    assign instr_valid = valid_q;
    assign misaligned  = misaligned_q;
`ifdef PC_FETCH_TIMEOUT_EN
    assign fetch_timeout = timeout_q;
`else
    assign fetch_timeout = 1'b0;
`endif

    // Next-state logic: handshake sequencing, flush redirection, alignment trap.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        instr_d      = instr_q;
        pc_out_d     = pc_out_q;
        valid_d      = valid_q;
        misaligned_d = misaligned_q;
        flush_pend_d = flush_pend_q;
        flush_tgt_d  = flush_tgt_q;
        load_en      = 1'b0;
        load_addr    = next_pc;
`ifdef PC_FETCH_TIMEOUT_EN
        wait_d       = wait_q;
        timeout_d    = timeout_q;
`endif
        unique case (state_q)
            StIdle: begin
                state_d = StReq;
`ifdef PC_FETCH_TIMEOUT_EN
                wait_d  = '0;
`endif
            end
            StReq: begin
                if (imem_ack) begin
`ifdef PC_FETCH_TIMEOUT_EN
                    wait_d = '0;
`endif
                    if (flush || flush_pend_q) begin
                        // Returned word belongs to a squashed fetch: drop it and
                        // re-request at the redirect target without leaving StReq.
                        load_en      = 1'b1;
                        load_addr    = flush ? next_pc : flush_tgt_q;
                        flush_pend_d = 1'b0;
                    end else begin
                        instr_d  = imem_rdata;
                        pc_out_d = pc_q;
                        valid_d  = 1'b1;
                        state_d  = StHold;
                    end
                end else begin
                    // Address must stay stable until ack, so remember the redirect.
                    if (flush) begin
                        flush_pend_d = 1'b1;
                        flush_tgt_d  = next_pc;
                    end
`ifdef PC_FETCH_TIMEOUT_EN
                    wait_d = wait_q + 5'd1;
                    if (wait_d == TimeoutLim) begin
                        timeout_d = 1'b1;
                        state_d   = StErr;
                    end
`endif
                end
            end
            StHold: begin
                if (flush || !stall) begin
                    load_en = 1'b1;
                    valid_d = 1'b0;
                    state_d = StReq;
`ifdef PC_FETCH_TIMEOUT_EN
                    wait_d  = '0;
`endif
                end
            end
            StErr: begin
                state_d = StErr;
            end
            default: begin
                state_d = StErr;
            end
        endcase

        // A misaligned target never reaches the PC; it traps the unit instead.
        if (load_en) begin
            if (load_addr[1:0] != 2'b00) begin
                misaligned_d = 1'b1;
                valid_d      = 1'b0;
                state_d      = StErr;
            end else begin
                pc_d = load_addr;
            end
        end
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            pc_q         <= RESET_PC;
            instr_q      <= '0;
            pc_out_q     <= '0;
            valid_q      <= 1'b0;
            misaligned_q <= 1'b0;
            flush_pend_q <= 1'b0;
            flush_tgt_q  <= '0;
`ifdef PC_FETCH_TIMEOUT_EN
            wait_q       <= '0;
            timeout_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            instr_q      <= instr_d;
            pc_out_q     <= pc_out_d;
            valid_q      <= valid_d;
            misaligned_q <= misaligned_d;
            flush_pend_q <= flush_pend_d;
            flush_tgt_q  <= flush_tgt_d;
`ifdef PC_FETCH_TIMEOUT_EN
            wait_q       <= wait_d;
            timeout_q    <= timeout_d;
`endif
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios followed by
// randomized episodes, all compared against a transaction-level model.
module tb_pc_fetch_unit;

    localparam int unsigned TO = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] next_pc;
    logic        stall;
    logic        flush;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic        instr_valid;
    logic [31:0] pc_plus4;
    logic        misaligned;
    logic        fetch_timeout;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pc_fetch_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .next_pc      (next_pc),
        .stall        (stall),
        .flush        (flush),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .instr_out    (instr_out),
        .pc_out       (pc_out),
        .instr_valid  (instr_valid),
        .pc_plus4     (pc_plus4),
        .misaligned   (misaligned),
        .fetch_timeout(fetch_timeout)
    );

    // Reference model: "started" = left the post-reset idle cycle, "have" = an
    // instruction is being presented, "dead" = trapped until reset,
    // "redir" = a redirect arrived while a fetch was outstanding.
    bit          m_started, m_have, m_dead, m_redir, m_valid, m_mis, m_to;
    logic [31:0] m_pc, m_redir_addr, m_instr, m_pcout;
    int          m_wait;

    function automatic void model_reset();
        m_started = 0; m_have = 0; m_dead = 0; m_redir = 0;
        m_valid = 0; m_mis = 0; m_to = 0; m_wait = 0;
        m_pc = 32'h0; m_redir_addr = 32'h0; m_instr = 32'h0; m_pcout = 32'h0;
    endfunction

    function automatic void model_jump(input logic [31:0] a);
        if (a % 4 != 0) begin
            m_mis = 1; m_valid = 0; m_dead = 1;
        end else begin
            m_pc = a; m_have = 0; m_wait = 0;
        end
    endfunction

    function automatic void model_step();
        logic [31:0] t;
        if (m_dead) return;
        if (!m_started) begin
            m_started = 1; m_wait = 0;
            return;
        end
        if (m_have) begin
            if (flush || !stall) begin
                m_valid = 0;
                model_jump(next_pc);
            end
            return;
        end
        if (imem_ack) begin
            if (flush || m_redir) begin
                t = flush ? next_pc : m_redir_addr;
                m_redir = 0;
                model_jump(t);
            end else begin
                m_instr = imem_rdata; m_pcout = m_pc; m_valid = 1; m_have = 1;
            end
        end else begin
            if (flush) begin
                m_redir = 1; m_redir_addr = next_pc;
            end
`ifdef PC_FETCH_TIMEOUT_EN
            m_wait++;
            if (m_wait == TO) begin
                m_to = 1; m_dead = 1;
            end
`endif
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [31:0] e_p4;
        e_p4 = m_pc + 32'd4;
        chk({tag, "/req"}, {31'b0, imem_req}, {31'b0, m_started && !m_have && !m_dead});
        chk({tag, "/addr"}, imem_addr, m_pc);
        chk({tag, "/pc_plus4"}, pc_plus4, e_p4);
        chk({tag, "/instr"}, instr_out, m_instr);
        chk({tag, "/pc_out"}, pc_out, m_pcout);
        chk({tag, "/valid"}, {31'b0, instr_valid}, {31'b0, m_valid});
        chk({tag, "/misaligned"}, {31'b0, misaligned}, {31'b0, m_mis});
        chk({tag, "/timeout"}, {31'b0, fetch_timeout}, {31'b0, m_to});
    endtask

    // Advance one clock; inputs set since the previous step are what the DUT samples.
    task automatic cycle(input string tag);
        @(posedge clk);
        if (rst_n) model_step();
        #1;
        check_all(tag);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        model_reset();
        check_all("reset");
        @(posedge clk);
        #1;
        check_all("reset_hold");
        rst_n = 1'b1;
    endtask

    task automatic rand_inputs();
        int r;
        r = $urandom_range(0, 99);
        if (r < 65)      next_pc = m_pc + 32'd4;
        else if (r < 97) next_pc = {$urandom_range(0, 32'h3FFF), 2'b00};
        else             next_pc = {$urandom_range(0, 32'h3FFF), 2'b10};
        stall      = ($urandom_range(0, 99) < 40);
        flush      = ($urandom_range(0, 99) < 15);
        imem_ack   = ($urandom_range(0, 99) < 50);
        imem_rdata = $urandom;
    endtask

    initial begin
        rst_n = 1'b1; next_pc = '0; stall = 0; flush = 0; imem_ack = 0; imem_rdata = '0;
        model_reset();
        #3;

        // Reset release, ack one cycle after req.
        do_reset();
        cycle("t1_idle");
        chk("t1_req", {31'b0, imem_req}, 32'd1);
        chk("t1_addr", imem_addr, 32'h0);
        imem_ack = 1; imem_rdata = 32'h0050_0093;
        cycle("t1_ack");
        chk("t1_valid", {31'b0, instr_valid}, 32'd1);
        chk("t1_instr", instr_out, 32'h0050_0093);
        chk("t1_pc_out", pc_out, 32'h0);

        // Stall three cycles in hold, then advance to 4.
        imem_ack = 0; stall = 1; next_pc = 32'h4;
        for (int i = 0; i < 3; i++) begin
            cycle("t3_stall");
            chk("t3_req", {31'b0, imem_req}, 32'd0);
            chk("t3_instr", instr_out, 32'h0050_0093);
        end
        stall = 0;
        cycle("t3_release");
        chk("t3_addr", imem_addr, 32'h4);

        // Flush to 0x40 while requesting; ack arrives two cycles later.
        flush = 1; next_pc = 32'h40;
        cycle("t4_flush");
        chk("t4_addr_held", imem_addr, 32'h4);
        flush = 0; next_pc = 32'h100;
        cycle("t4_wait");
        imem_ack = 1; imem_rdata = 32'hDEAD_BEEF;
        cycle("t4_discard");
        chk("t4_valid", {31'b0, instr_valid}, 32'd0);
        chk("t4_redir_addr", imem_addr, 32'h40);
        imem_rdata = 32'h0000_0013;
        cycle("t4_fetch");
        chk("t4_pc_out", pc_out, 32'h40);

        // Misaligned advance traps until reset.
        imem_ack = 0; next_pc = 32'h42;
        cycle("t5_trap");
        chk("t5_mis", {31'b0, misaligned}, 32'd1);
        chk("t5_req", {31'b0, imem_req}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            rand_inputs();
            cycle("t5_frozen");
        end
        do_reset();
        chk("t5_cleared", {31'b0, misaligned}, 32'd0);

        // Sequential fetch 0,4,8,12 with same-cycle ack; also wrap check below.
        stall = 0; flush = 0; imem_ack = 1;
        for (int k = 0; k < 4; k++) begin
            next_pc = 32'(4 * k);
            imem_rdata = 32'(k + 100);
            cycle("t2_req");
            chk("t2_addr", imem_addr, 32'(4 * k));
            cycle("t2_hold");
            chk("t2_pc_out", pc_out, 32'(4 * k));
        end

        // Advance to the top word; pc_plus4 wraps.
        next_pc = 32'hFFFF_FFFC;
        cycle("wrap");
        chk("wrap_p4", pc_plus4, 32'h0);

        // No ack: timeout with the macro, endless request without.
        do_reset();
        imem_ack = 0;
        for (int i = 0; i < 100; i++) cycle("t6_wait");
`ifdef PC_FETCH_TIMEOUT_EN
        chk("t6_timeout", {31'b0, fetch_timeout}, 32'd1);
        chk("t6_req", {31'b0, imem_req}, 32'd0);
`else
        chk("t6_req", {31'b0, imem_req}, 32'd1);
`endif

        // Randomized episodes.
        for (int e = 0; e < 8; e++) begin
            do_reset();
            for (int i = 0; i < 200; i++) begin
                rand_inputs();
                cycle("rand");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
